// File: rtl/sha3_miner_pkg.sv
// Shared definitions for the SHA3-256 miner nonce sequencer: field widths,
// control/status bit positions and the sequencer state encoding.
package sha3_miner_pkg;

    localparam int NONCE_W = 64;
    localparam int HASH_W  = 256;
    localparam int CTRL_W  = 19;
    localparam int STAT_W  = 7;
    localparam int LIMIT_W = 32;

    // control register fields
    localparam int RUN_BIT       = 0;
    localparam int TEST_BIT      = 1;
    localparam int HALT_BIT      = 2;
    localparam int PAD_LAST_LSB  = 3;
    localparam int PAD_LAST_MSB  = 10;
    localparam int PAD_FIRST_LSB = 11;
    localparam int PAD_FIRST_MSB = 18;

    // status register fields
    localparam int STAT_FOUND_BIT   = 0;
    localparam int STAT_RUNNING_BIT = 1;
    localparam int STAT_TESTING_BIT = 2;
    localparam int STAT_STAGES_LSB  = 3;
    localparam int STAT_STAGES_MSB  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FOUND = 2'd2,
        ST_DONE  = 2'd3
    } miner_state_e;

endpackage

// File: rtl/sha3_nonce_delay.sv
// STAGES-deep shift register of {valid, nonce} that mirrors the keccak
// pipeline, so the entry at the tail is the nonce whose hash is arriving now.
// flush clears every valid bit (including the one being shifted in).
module sha3_nonce_delay
    import sha3_miner_pkg::*;
#(
    parameter int unsigned STAGES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [NONCE_W-1:0] in_nonce,
    output logic               out_valid,
    output logic [NONCE_W-1:0] out_nonce,
    output logic               any_valid
);

    logic               stage_valid_q [STAGES];
    logic               stage_valid_d [STAGES];
    logic [NONCE_W-1:0] stage_nonce_q [STAGES];
    logic [NONCE_W-1:0] stage_nonce_d [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic               prev_valid;
            logic [NONCE_W-1:0] prev_nonce;

            if (gi == 0) begin : g_head
                assign prev_valid = in_valid;
                assign prev_nonce = in_nonce;
            end else begin : g_body
                assign prev_valid = stage_valid_q[gi-1];
                assign prev_nonce = stage_nonce_q[gi-1];
            end

            // shift one place per clock; flush kills the valid bit
            always_comb begin
                stage_valid_d[gi] = prev_valid & ~flush;
                stage_nonce_d[gi] = prev_nonce;
            end

            // stage register
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_valid_q[gi] <= 1'b0;
                    stage_nonce_q[gi] <= '0;
                end else begin
                    stage_valid_q[gi] <= stage_valid_d[gi];
                    stage_nonce_q[gi] <= stage_nonce_d[gi];
                end
            end
        end
    endgenerate

    assign out_valid = stage_valid_q[STAGES-1];
    assign out_nonce = stage_nonce_q[STAGES-1];

    // any nonce still in flight (used to decide when draining is complete)
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            any_valid = any_valid | stage_valid_q[i];
        end
    end

endmodule

// File: rtl/sha3_miner_seq.sv
// Nonce sequencer and result checker for the SHA3-256 mining core.
// Issues one nonce per clock while running, tracks in-flight nonces through a
// delay line matching the keccak latency, and captures the first nonce whose
// hash is strictly below the difficulty target.
// Optional build macro SHA3_MINER_NONCE_LIMIT_EN adds a nonce_limit input that
// bounds the number of nonces issued per run (0 = unlimited).
module sha3_miner_seq
    import sha3_miner_pkg::*;
#(
    parameter int unsigned STAGES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        start_nonce,
    input  logic [255:0]       difficulty,
    input  logic [18:0]        control,
`ifdef SHA3_MINER_NONCE_LIMIT_EN
    input  logic [31:0]        nonce_limit,
`endif
    input  logic [255:0]       hash_in,
    input  logic               hash_valid,
    output logic [63:0]        nonce_out,
    output logic               nonce_valid,
    output logic [7:0]         pad_first,
    output logic [7:0]         pad_last,
    output logic [63:0]        solution,
    output logic [6:0]         status,
    output logic               irq
);

    localparam logic [3:0] STAGES_FIELD = 4'(STAGES);

    miner_state_e       state_q,       state_d;
    logic [NONCE_W-1:0] counter_q,     counter_d;
    logic [NONCE_W-1:0] start_q,       start_d;
    logic [NONCE_W-1:0] nonce_out_q,   nonce_out_d;
    logic               nonce_valid_q, nonce_valid_d;
    logic               issuing_q,     issuing_d;
    logic [NONCE_W-1:0] solution_q,    solution_d;
    logic               found_q,       found_d;
    logic               running_q,     running_d;
    logic               testing_q,     testing_d;
    logic [7:0]         pad_first_q,   pad_first_d;
    logic [7:0]         pad_last_q,    pad_last_d;
`ifdef SHA3_MINER_NONCE_LIMIT_EN
    logic [LIMIT_W-1:0] issued_cnt_q,  issued_cnt_d;
    logic [LIMIT_W-1:0] issued_inc;
`endif

    logic               run_req;
    logic               halt_req;
    logic [NONCE_W-1:0] counter_inc;
    logic               dly_flush;
    logic               tail_valid;
    logic [NONCE_W-1:0] tail_nonce;
    logic               dly_any_valid;
    logic               hit;

    assign run_req     = control[RUN_BIT];
    assign halt_req    = control[HALT_BIT];
    assign counter_inc = counter_q + 64'd1;
`ifdef SHA3_MINER_NONCE_LIMIT_EN
    assign issued_inc  = issued_cnt_q + 32'd1;
`endif

    // A returned hash counts only when it pairs with a live in-flight nonce;
    // test mode forces the single test nonce to be accepted.
    assign hit = (state_q == ST_RUN) && hash_valid && tail_valid &&
                 ((hash_in < difficulty) || testing_q);

    sha3_nonce_delay #(
        .STAGES (STAGES)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .flush     (dly_flush),
        .in_valid  (nonce_valid_q),
        .in_nonce  (nonce_out_q),
        .out_valid (tail_valid),
        .out_nonce (tail_nonce),
        .any_valid (dly_any_valid)
    );

    // next-state and output logic of the run sequencer
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        start_d       = start_q;
        nonce_out_d   = nonce_out_q;
        nonce_valid_d = 1'b0;
        issuing_d     = issuing_q;
        solution_d    = solution_q;
        found_d       = found_q;
        running_d     = running_q;
        testing_d     = testing_q;
        pad_first_d   = pad_first_q;
        pad_last_d    = pad_last_q;
        dly_flush     = (state_q != ST_RUN);
`ifdef SHA3_MINER_NONCE_LIMIT_EN
        issued_cnt_d  = issued_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (run_req && !halt_req) begin
                    counter_d   = start_nonce;
                    start_d     = start_nonce;
                    pad_first_d = control[PAD_FIRST_MSB:PAD_FIRST_LSB];
                    pad_last_d  = control[PAD_LAST_MSB:PAD_LAST_LSB];
                    testing_d   = control[TEST_BIT];
                    found_d     = 1'b0;
                    solution_d  = '0;
                    issuing_d   = 1'b1;
                    running_d   = 1'b1;
`ifdef SHA3_MINER_NONCE_LIMIT_EN
                    issued_cnt_d = '0;
`endif
                    state_d     = ST_RUN;
                end
            end

            ST_RUN: begin
                if (halt_req) begin
                    // halt beats a simultaneous hit: abandon without capture
                    issuing_d = 1'b0;
                    running_d = 1'b0;
                    dly_flush = 1'b1;
                    state_d   = ST_IDLE;
                end else if (hit) begin
                    solution_d = tail_nonce;
                    found_d    = 1'b1;
                    issuing_d  = 1'b0;
                    running_d  = 1'b0;
                    dly_flush  = 1'b1;
                    state_d    = ST_FOUND;
                end else if (issuing_q) begin
                    nonce_out_d   = counter_q;
                    nonce_valid_d = 1'b1;
                    counter_d     = counter_inc;
                    // test mode issues one nonce; wrapping back to the start
                    // means the whole nonce space has been covered
                    if (testing_q || (counter_inc == start_q)) begin
                        issuing_d = 1'b0;
                    end
`ifdef SHA3_MINER_NONCE_LIMIT_EN
                    issued_cnt_d = issued_inc;
                    if ((nonce_limit != '0) && (issued_inc == nonce_limit)) begin
                        issuing_d = 1'b0;
                    end
`endif
                end else if (!nonce_valid_q && !dly_any_valid) begin
                    // all in-flight nonces drained without a hit
                    running_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end

            ST_FOUND, ST_DONE: begin
                // the run bit must drop before another run may start
                if (!run_req) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // sequencer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            counter_q     <= '0;
            start_q       <= '0;
            nonce_out_q   <= '0;
            nonce_valid_q <= 1'b0;
            issuing_q     <= 1'b0;
            solution_q    <= '0;
            found_q       <= 1'b0;
            running_q     <= 1'b0;
            testing_q     <= 1'b0;
            pad_first_q   <= '0;
            pad_last_q    <= '0;
`ifdef SHA3_MINER_NONCE_LIMIT_EN
            issued_cnt_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            start_q       <= start_d;
            nonce_out_q   <= nonce_out_d;
            nonce_valid_q <= nonce_valid_d;
            issuing_q     <= issuing_d;
            solution_q    <= solution_d;
            found_q       <= found_d;
            running_q     <= running_d;
            testing_q     <= testing_d;
            pad_first_q   <= pad_first_d;
            pad_last_q    <= pad_last_d;
`ifdef SHA3_MINER_NONCE_LIMIT_EN
            issued_cnt_q  <= issued_cnt_d;
`endif
        end
    end

    assign nonce_out   = nonce_out_q;
    assign nonce_valid = nonce_valid_q;
    assign pad_first   = pad_first_q;
    assign pad_last    = pad_last_q;
    assign solution    = solution_q;
    assign status      = {STAGES_FIELD, testing_q, running_q, found_q};
    assign irq         = found_q;

endmodule

// File: tb/tb_sha3_miner_seq.sv
// Self-checking bench for sha3_miner_seq: a behavioural keccak pipeline model
// returns hashes STAGES clocks after each issued nonce; expected issue order is
// queued per run and popped as nonce_valid pulses appear.
module tb_sha3_miner_seq;

    localparam int STAGES = 8;
    localparam logic [255:0] D255 = {1'b1, 255'd0};
    localparam logic [255:0] ALL1 = {256{1'b1}};

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  start_nonce;
    logic [255:0] difficulty;
    logic [18:0]  control;
    logic [31:0]  nonce_limit;
    logic [255:0] hash_in;
    logic         hash_valid;
    logic [63:0]  nonce_out;
    logic         nonce_valid;
    logic [7:0]   pad_first;
    logic [7:0]   pad_last;
    logic [63:0]  solution;
    logic [6:0]   status;
    logic         irq;

    sha3_miner_seq #(.STAGES(STAGES)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_nonce (start_nonce),
        .difficulty  (difficulty),
        .control     (control),
`ifdef SHA3_MINER_NONCE_LIMIT_EN
        .nonce_limit (nonce_limit),
`endif
        .hash_in     (hash_in),
        .hash_valid  (hash_valid),
        .nonce_out   (nonce_out),
        .nonce_valid (nonce_valid),
        .pad_first   (pad_first),
        .pad_last    (pad_last),
        .solution    (solution),
        .status      (status),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  start;
        logic [255:0] diff;
        logic         test;
        logic [7:0]   pf;
        logic [7:0]   pl;
        logic [63:0]  n0;
        logic [255:0] h0;
        logic [63:0]  n1;
        logic [255:0] h1;
        int           n_issue;
        logic [63:0]  exp_sol;
        logic [6:0]   exp_status;
    } vec_t;

    vec_t vecs [4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int issues   = 0;
    int lat_cyc  = -1000;
    logic [63:0] lat_nonce;

    logic [63:0]  exp_q [$];
    logic [64:0]  pipe_q [$];
    logic [63:0]  sp_nonce [2];
    logic [255:0] sp_hash  [2];
    logic         halt_arm = 1'b0;
    logic [63:0]  halt_nonce = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=timeout required=event", name);
    endtask

    function automatic logic [255:0] model_hash(input logic [63:0] n);
        if (n == sp_nonce[0]) return sp_hash[0];
        if (n == sp_nonce[1]) return sp_hash[1];
        return ALL1;
    endfunction

    // one clock: scoreboard issued nonces, then advance the pipeline model
    task automatic tick();
        logic [64:0] ent;
        logic [63:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (nonce_valid) begin
            issues++;
            if (nonce_out == lat_nonce) lat_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_issue got=%0h required=none", nonce_out);
            end else begin
                e = exp_q.pop_front();
                chk("issue_nonce", nonce_out, e);
            end
        end
        pipe_q.push_back({nonce_valid, nonce_out});
        hash_valid = 1'b0;
        hash_in    = ALL1;
        if (pipe_q.size() > STAGES) begin
            ent = pipe_q.pop_front();
            if (ent[64]) begin
                hash_valid = 1'b1;
                hash_in    = model_hash(ent[63:0]);
                if (halt_arm && ent[63:0] == halt_nonce) control[2] = 1'b1;
            end
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_seq(input logic [63:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 64'(i));
    endtask

    // full run from IDLE through FOUND and back to IDLE
    task automatic run_case(input string name, input vec_t v);
        int found_cyc = -1;
        sp_nonce[0] = v.n0; sp_hash[0] = v.h0;
        sp_nonce[1] = v.n1; sp_hash[1] = v.h1;
        start_nonce = v.start;
        difficulty  = v.diff;
        lat_nonce   = v.exp_sol;
        lat_cyc     = -1000;
        push_seq(v.start, v.n_issue);
        control = {v.pf, v.pl, 1'b0, v.test, 1'b1};
        for (int k = 0; k < 200 && found_cyc < 0; k++) begin
            tick();
            if (k == 0) chk({name, "_run_flags"}, 256'(status[2:1]), 256'({v.test, 1'b1}));
            if (status[0]) found_cyc = cyc;
        end
        if (found_cyc < 0) fail_now({name, "_found"});
        chk({name, "_solution"}, 256'(solution), 256'(v.exp_sol));
        chk({name, "_status"}, 256'(status), 256'(v.exp_status));
        chk({name, "_irq"}, 256'(irq), 256'(1));
        chk({name, "_latency"}, 256'(found_cyc - lat_cyc), 256'(STAGES + 1));
        chk({name, "_pads"}, 256'({pad_first, pad_last}), 256'({v.pf, v.pl}));
        idle_ticks(3);
        chk({name, "_hold_status"}, 256'(status), 256'(v.exp_status));
        chk({name, "_issue_count"}, 256'(exp_q.size()), 256'(0));
        control = '0;
        idle_ticks(STAGES + 2);
        chk({name, "_idle_sol"}, 256'(solution), 256'(v.exp_sol));
        $display("case %s solution=%0h status=%0h", name, solution, status);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{start:64'h100, diff:D255, test:1'b0, pf:8'h06, pl:8'h80,
                    n0:64'h105, h0:256'h1, n1:64'hFFFF_0000_0000_0000, h1:ALL1,
                    n_issue:6 + STAGES, exp_sol:64'h105, exp_status:7'h41};
        vecs[1] = '{start:64'hDEAD, diff:256'h0, test:1'b1, pf:8'h01, pl:8'h81,
                    n0:64'hFFFF_0000_0000_0000, h0:ALL1, n1:64'hFFFF_0000_0000_0001, h1:ALL1,
                    n_issue:1, exp_sol:64'hDEAD, exp_status:7'h45};
        vecs[2] = '{start:64'h0, diff:256'h1000, test:1'b0, pf:8'h1F, pl:8'h80,
                    n0:64'h3, h0:256'h1000, n1:64'h4, h1:256'hFFF,
                    n_issue:5 + STAGES, exp_sol:64'h4, exp_status:7'h41};
        vecs[3] = '{start:64'h7, diff:D255, test:1'b0, pf:8'hA5, pl:8'h5A,
                    n0:64'h7, h0:256'h0, n1:64'hFFFF_0000_0000_0000, h1:ALL1,
                    n_issue:1 + STAGES, exp_sol:64'h7, exp_status:7'h41};

        rst = 1'b1; control = '0; nonce_limit = '0; start_nonce = '0;
        difficulty = '0; hash_in = '0; hash_valid = 1'b0; lat_nonce = '1;
        sp_nonce[0] = '1; sp_nonce[1] = '1; sp_hash[0] = ALL1; sp_hash[1] = ALL1;
        idle_ticks(3);
        chk("rst_nonce_out", 256'(nonce_out), 256'(0));
        chk("rst_nonce_valid", 256'(nonce_valid), 256'(0));
        chk("rst_solution", 256'(solution), 256'(0));
        chk("rst_status", 256'(status), 256'(7'h40));
        chk("rst_irq", 256'(irq), 256'(0));
        chk("rst_pads", 256'({pad_first, pad_last}), 256'(0));
        rst = 1'b0;
        idle_ticks(2);
        chk("idle_status", 256'(status), 256'(7'h40));

        for (int i = 0; i < 4; i++) run_case($sformatf("vec%0d", i), vecs[i]);

        // wrap across 2^64 with no hits; halt stops issue on the next clock
        start_nonce = 64'hFFFF_FFFF_FFFF_FFFE; difficulty = '0;
        push_seq(start_nonce, 4);
        issues = 0;
        control = 19'h1;
        for (int k = 0; k < 50 && issues < 4; k++) tick();
        if (issues < 4) fail_now("wrap_issue");
        chk("wrap_running", 256'(status[1]), 256'(1));
        control = 19'h4;
        tick();
        chk("wrap_halt_status", 256'(status), 256'(7'h40));
        control = '0;
        idle_ticks(STAGES + 2);
        chk("wrap_issue_count", 256'(exp_q.size()), 256'(0));
        $display("case wrap issues=%0d", issues);

        // hit and halt in the same cycle: halt wins, then a fresh run restarts
        start_nonce = 64'h20; difficulty = D255;
        sp_nonce[0] = 64'h22; sp_hash[0] = 256'h1;
        sp_nonce[1] = '1;     sp_hash[1] = ALL1;
        halt_arm = 1'b1; halt_nonce = 64'h22;
        push_seq(64'h20, 3 + STAGES);
        control = 19'h1;
        for (int k = 0; k < 100 && !control[2]; k++) tick();
        if (!control[2]) fail_now("halt_hit_arm");
        tick();
        halt_arm = 1'b0;
        chk("halt_hit_status", 256'(status), 256'(7'h40));
        chk("halt_hit_solution", 256'(solution), 256'(0));
        control = '0;
        idle_ticks(STAGES + 2);
        chk("halt_hit_found", 256'(status[0]), 256'(0));
        chk("halt_hit_issue_count", 256'(exp_q.size()), 256'(0));
        $display("case halt_hit status=%0h", status);
        rv = '{start:64'h20, diff:D255, test:1'b0, pf:8'h06, pl:8'h80,
               n0:64'h20, h0:256'h1, n1:64'hFFFF_0000_0000_0000, h1:ALL1,
               n_issue:1 + STAGES, exp_sol:64'h20, exp_status:7'h41};
        run_case("restart", rv);

        // reset with five nonces in flight; their hashes must then be ignored
        start_nonce = 64'h300; difficulty = D255;
        sp_nonce[0] = 64'h302; sp_hash[0] = 256'h1;
        push_seq(64'h300, 5);
        issues = 0;
        control = 19'h1;
        for (int k = 0; k < 50 && issues < 5; k++) tick();
        if (issues < 5) fail_now("reset_issue");
        rst = 1'b1; control = '0;
        tick();
        chk("mid_rst_nonce_out", 256'(nonce_out), 256'(0));
        chk("mid_rst_nonce_valid", 256'(nonce_valid), 256'(0));
        chk("mid_rst_solution", 256'(solution), 256'(0));
        chk("mid_rst_status", 256'(status), 256'(7'h40));
        chk("mid_rst_pads", 256'({pad_first, pad_last, irq}), 256'(0));
        rst = 1'b0;
        idle_ticks(STAGES + 2);
        chk("post_rst_found", 256'({status, irq}), 256'({7'h40, 1'b0}));
        chk("post_rst_issue_count", 256'(exp_q.size()), 256'(0));
        $display("case mid_reset status=%0h", status);

`ifdef SHA3_MINER_NONCE_LIMIT_EN
        // limited run: four fruitless nonces, drain, then DONE
        start_nonce = 64'h500; difficulty = '0; nonce_limit = 32'd4;
        sp_nonce[0] = '1; sp_hash[0] = ALL1;
        push_seq(64'h500, 4);
        control = 19'h1;
        tick();
        chk("limit_running", 256'(status[1]), 256'(1));
        for (int k = 0; k < 100 && status[1]; k++) tick();
        chk("limit_done_status", 256'(status), 256'(7'h40));
        idle_ticks(3);
        chk("limit_hold_status", 256'(status), 256'(7'h40));
        chk("limit_issue_count", 256'(exp_q.size()), 256'(0));
        control = '0; nonce_limit = '0;
        idle_ticks(STAGES + 2);
        $display("case nonce_limit status=%0h", status);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
